// File: rtl/add_responder.sv
// Operand/sum responder: accepts (a, b) pairs, stores {a, b, a+b} in a small FIFO
// and returns them in order over a second valid/ready handshake.
module add_responder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_a,
    output logic [WIDTH-1:0]           out_b,
    output logic [WIDTH:0]             out_y,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           txn_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [WIDTH-1:0] a_mem [DEPTH];
    logic [WIDTH-1:0] b_mem [DEPTH];
    logic [WIDTH:0]   y_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [CNT_W-1:0] txn_count_reg;

    logic             push_en;
    logic             pop_en;
    logic [WIDTH:0]   sum_next;
    logic [LVL_W-1:0] level_next;

    // Handshake readiness depends only on stored occupancy, never on out_ready.
    assign in_ready  = (level_reg < DEPTH_LVL);
    assign out_valid = (level_reg != '0);

    // Flush wins over both handshakes; a pair offered alongside flush is dropped.
    assign push_en  = in_valid && in_ready && !flush;
    assign pop_en   = out_valid && out_ready && !flush;
    assign sum_next = {1'b0, in_a} + {1'b0, in_b};

    always_comb begin
        level_next = level_reg;
        if (push_en && !pop_en) begin
            level_next = level_reg + LVL_ONE;
        end else if (pop_en && !push_en) begin
            level_next = level_reg - LVL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            txn_count_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg    <= wr_ptr_reg + PTR_ONE;
                txn_count_reg <= txn_count_reg + CNT_ONE;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            level_reg <= level_next;
        end
    end

    // Storage needs no reset: its contents are only observable while level is non-zero.
    always_ff @(posedge clk) begin
        if (push_en) begin
            a_mem[wr_ptr_reg] <= in_a;
            b_mem[wr_ptr_reg] <= in_b;
            y_mem[wr_ptr_reg] <= sum_next;
        end
    end

    assign out_a     = out_valid ? a_mem[rd_ptr_reg] : '0;
    assign out_b     = out_valid ? b_mem[rd_ptr_reg] : '0;
    assign out_y     = out_valid ? y_mem[rd_ptr_reg] : '0;
    assign level     = level_reg;
    assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_add_responder.sv
// Bench for add_responder: directed stimulus, a queue-based reference model
// checked every negedge, plus hand-computed literal expectations.
module tb_add_responder;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH:0]   out_y;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0] txn_count;

    int n_checks = 0;
    int n_pass   = 0;

    add_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_y     (out_y),
        .level     (level),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int y;
    } entry_t;

    entry_t model_q[$];
    int     model_cnt = 0;

    // Reference model: an ordinary queue of {a, b, a+b} plus an accept counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            model_cnt = 0;
        end else begin
            bit do_push;
            bit do_pop;
            entry_t e;
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = out_ready && (model_q.size() > 0);
            if (flush) begin
                model_q.delete();
            end else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    e.a = int'(in_a);
                    e.b = int'(in_b);
                    e.y = int'(in_a) + int'(in_b);
                    model_q.push_back(e);
                    model_cnt = (model_cnt + 1) % (1 << CNT_W);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("model_level", int'(level), model_q.size());
        chk("model_in_ready", int'(in_ready), (model_q.size() < DEPTH) ? 1 : 0);
        chk("model_out_valid", int'(out_valid), (model_q.size() > 0) ? 1 : 0);
        chk("model_txn_count", int'(txn_count), model_cnt);
        if (model_q.size() > 0) begin
            chk("model_out_a", int'(out_a), model_q[0].a);
            chk("model_out_b", int'(out_b), model_q[0].b);
            chk("model_out_y", int'(out_y), model_q[0].y);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b);
        in_valid = 1'b1;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
    endtask

    int base;

    initial begin
        // Reset
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_level", int'(level), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_txn_count", int'(txn_count), 0);
        chk("rst_out_y", int'(out_y), 0);

        // Three back-to-back pairs, each visible one cycle after its push
        out_ready = 1'b1;
        drive(1, 3); step(); chk("seq_y0", int'(out_y), 4);
        drive(5, 6); step(); chk("seq_y1", int'(out_y), 11);
        drive(7, 8); step(); chk("seq_y2", int'(out_y), 15);
        in_valid = 1'b0;
        step();
        chk("seq_txn", int'(txn_count), 3);
        chk("seq_empty", int'(out_valid), 0);

        // Maximum operands: 15 + 15 = 30 with no overflow
        out_ready = 1'b0;
        drive(15, 15); step();
        in_valid = 1'b0;
        chk("max_y", int'(out_y), 30);
        chk("max_a", int'(out_a), 15);
        chk("max_b", int'(out_b), 15);
        out_ready = 1'b1;
        step();
        chk("max_drained", int'(level), 0);

        // Stall: five pairs against a blocked consumer
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(i + 1, 2 * i);
            step();
        end
        chk("full_level", int'(level), 4);
        chk("full_in_ready", int'(in_ready), 0);
        drive(9, 4);
        step();
        step();
        chk("stall_head_y", int'(out_y), 1);
        chk("stall_head_a", int'(out_a), 1);
        chk("stall_level", int'(level), 4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_level", int'(level), 3);
        chk("pop_in_ready", int'(in_ready), 1);
        chk("pop_head_y", int'(out_y), 4);
        step();
        in_valid = 1'b0;
        chk("held_accepted_level", int'(level), 4);
        chk("stall_txn", int'(txn_count), 9);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("stall_drained", int'(level), 0);

        // Continuous push/pop across pointer wrap
        base = int'(txn_count);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            step();
            chk("stream_level", int'(level), 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_txn", int'(txn_count) - base, 10);

        // Flush with concurrent push: push dropped, counter kept
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1);
            step();
        end
        base = int'(txn_count);
        drive(6, 6);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_level", int'(level), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_txn", int'(txn_count), base);

        // Asynchronous reset with two entries queued
        drive(2, 2); step();
        drive(3, 3); step();
        in_valid = 1'b0;
        chk("pre_rst_level", int'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_txn", int'(txn_count), 0);
        chk("arst_out_y", int'(out_y), 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(2, 3); step();
        in_valid = 1'b0;
        chk("post_rst_y", int'(out_y), 5);
        chk("post_rst_txn", int'(txn_count), 1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
